// File: rtl/apu_frame_counter.sv
// rtl/apu_frame_counter.sv - APU frame sequencer
// Quarter/half-frame clock generator with frame-interrupt flag and deferred $4017 sequence reset.
module apu_frame_counter #(
  parameter int unsigned STEP1 = 7457,
  parameter int unsigned STEP2 = 14913,
  parameter int unsigned STEP3 = 22371,
  parameter int unsigned STEP4 = 29829,
  parameter int unsigned STEP5 = 37281
) (
  input  logic       clk_ph2_i,
  input  logic       rst_i,
  input  logic       wr_4017_i,
  input  logic [7:0] din_i,
  input  logic       rd_4015_i,
  output logic       q_frame_o,
  output logic       h_frame_o,
  output logic       frame_irq_o,
  output logic       irq_o
);

  localparam logic [15:0] S1   = 16'(STEP1);
  localparam logic [15:0] S2   = 16'(STEP2);
  localparam logic [15:0] S3   = 16'(STEP3);
  localparam logic [15:0] S4   = 16'(STEP4);
  localparam logic [15:0] S4M1 = 16'(STEP4 - 1);
  localparam logic [15:0] S5   = 16'(STEP5);

  typedef enum logic {ST_IDLE, ST_PENDING} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  dly_q, dly_d;
  logic        mode_q, mode_d;
  logic        inhibit_q, inhibit_d;
  logic        pend_mode_q, pend_mode_d;
  logic        parity_q, parity_d;
  logic        wrap4_q, wrap4_d;
  logic        exp5_q, exp5_d;
  logic        q_q, q_d;
  logic        h_q, h_d;
  logic        flag_q, flag_d;

  logic hit1, hit2, hit3, hit4, hit4m1, hit5;
  logic at_wrap, expire, step_qh, irq_set, irq_kill;
  logic unused_din;

  assign unused_din = ^din_i[5:0];

  assign hit1   = (cnt_q == S1);
  assign hit2   = (cnt_q == S2);
  assign hit3   = (cnt_q == S3);
  assign hit4   = (cnt_q == S4);
  assign hit4m1 = (cnt_q == S4M1);
  assign hit5   = (cnt_q == S5);

  assign at_wrap = mode_q ? hit5 : hit4;
  // dly counts the edges still to go; the edge where it would reach zero performs the reset
  assign expire  = (state_q == ST_PENDING) && !wr_4017_i && (dly_q == 3'd1);
  assign step_qh = hit2 || (!mode_q && hit4) || (mode_q && hit5);

  assign irq_set  = !mode_q && !inhibit_q && (hit4m1 || hit4 || wrap4_q);
  assign irq_kill = wr_4017_i && din_i[6];

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    pend_mode_d = pend_mode_q;
    mode_d      = mode_q;
    inhibit_d   = inhibit_q;
    exp5_d      = 1'b0;
    cnt_d       = at_wrap ? 16'd0 : cnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (wr_4017_i) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (expire) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
          mode_d  = pend_mode_q;
          exp5_d  = pend_mode_q;
        end else if (!wr_4017_i) begin
          dly_d = dly_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write (also one landing while pending) restarts the delay from the current parity
    if (wr_4017_i) begin
      inhibit_d   = din_i[6];
      pend_mode_d = din_i[7];
      dly_d       = parity_q ? 3'd3 : 3'd2;
    end
  end

  always_comb begin
    parity_d = ~parity_q;
    wrap4_d  = !mode_q && hit4;
    q_d      = exp5_q || (!expire && (hit1 || hit3 || step_qh));
    h_d      = exp5_q || (!expire && step_qh);
    flag_d   = flag_q;
    if (irq_kill) begin
      flag_d = 1'b0;
    end else if (irq_set) begin
      flag_d = 1'b1;
    end else if (rd_4015_i) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk_ph2_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      dly_q       <= 3'd0;
      mode_q      <= 1'b0;
      inhibit_q   <= 1'b0;
      pend_mode_q <= 1'b0;
      parity_q    <= 1'b0;
      wrap4_q     <= 1'b0;
      exp5_q      <= 1'b0;
      q_q         <= 1'b0;
      h_q         <= 1'b0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      mode_q      <= mode_d;
      inhibit_q   <= inhibit_d;
      pend_mode_q <= pend_mode_d;
      parity_q    <= parity_d;
      wrap4_q     <= wrap4_d;
      exp5_q      <= exp5_d;
      q_q         <= q_d;
      h_q         <= h_d;
      flag_q      <= flag_d;
    end
  end

  assign q_frame_o   = q_q;
  assign h_frame_o   = h_q;
  assign frame_irq_o = flag_q;
  assign irq_o       = ~flag_q;

endmodule

// File: tb/tb_apu_frame_counter.sv
// tb/tb_apu_frame_counter.sv - scoreboard bench for apu_frame_counter
// Short step points keep several frames within a small cycle budget.
module tb_apu_frame_counter;

  localparam int S1 = 75;
  localparam int S2 = 149;
  localparam int S3 = 224;
  localparam int S4 = 298;
  localparam int S5 = 373;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rd = 1'b0;
  logic       q_frame, h_frame, frame_irq, irq;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic irq_prev = 1'b1;

  typedef struct {
    int cyc;
    bit q;
    bit h;
    bit irq;
  } ev_t;

  ev_t sb[$];

  apu_frame_counter #(
    .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4), .STEP5(S5)
  ) dut (
    .clk_ph2_i  (clk),
    .rst_i      (rst),
    .wr_4017_i  (wr),
    .din_i      (din),
    .rd_4015_i  (rd),
    .q_frame_o  (q_frame),
    .h_frame_o  (h_frame),
    .frame_irq_o(frame_irq),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Monitor: every pulse or irq transition must match the next expected event
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (q_frame || h_frame || irq !== irq_prev)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL event unexpected: cyc=%0d q=%b h=%b irq=%b", cyc, q_frame, h_frame, irq);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || q_frame !== e.q || h_frame !== e.h || irq !== e.irq || frame_irq !== ~e.irq) begin
          bad++;
          $display("FAIL event: act cyc=%0d q=%b h=%b irq=%b fi=%b, exp cyc=%0d q=%b h=%b irq=%b fi=%b",
                   cyc, q_frame, h_frame, irq, frame_irq, e.cyc, e.q, e.h, e.irq, ~e.irq);
        end
      end
    end
    irq_prev = irq;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic ev(input int c, input bit q, input bit h, input bit i);
    ev_t e;
    e.cyc = c; e.q = q; e.h = h; e.irq = i;
    sb.push_back(e);
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wr_pulse(input logic [7:0] d);
    wr = 1'b1; din = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_q"}, int'(q_frame), 0);
    chk({tag, "_h"}, int'(h_frame), 0);
    chk({tag, "_fi"}, int'(frame_irq), 0);
    chk({tag, "_irq"}, int'(irq), 1);
  endtask

  task automatic chk_drained(input string name);
    int front;
    front = (sb.size() != 0) ? sb[0].cyc : -1;
    chk(name, sb.size(), 0);
    if (sb.size() != 0) $display("  pending event at cyc=%0d", front);
    sb.delete();
  endtask

  initial begin
    // 4-step run, acknowledge, set-vs-read races, then inhibit over three frames
    do_reset();
    chk_reset_vals("reset");
    ev(76, 1, 0, 1);  ev(150, 1, 1, 1); ev(225, 1, 0, 1);
    ev(298, 0, 0, 0); ev(299, 1, 1, 0);
    ev(311, 0, 0, 1);
    ev(375, 1, 0, 1); ev(449, 1, 1, 1); ev(524, 1, 0, 1);
    ev(597, 0, 0, 0); ev(598, 1, 1, 1);
    ev(677, 1, 0, 1); ev(751, 1, 1, 1); ev(826, 1, 0, 1); ev(900, 1, 1, 1);
    ev(976, 1, 0, 1); ev(1050, 1, 1, 1); ev(1125, 1, 0, 1); ev(1199, 1, 1, 1);
    ev(1275, 1, 0, 1); ev(1349, 1, 1, 1); ev(1424, 1, 0, 1); ev(1498, 1, 1, 1);
    goto_cyc(298); rd_pulse(); rd_pulse();
    goto_cyc(310); rd_pulse();
    goto_cyc(597); wr_pulse(8'h40);
    goto_cyc(1505);
    chk_drained("four_step_inhibit");

    // 5-step write on even parity, wrap at STEP5
    do_reset();
    ev(14, 1, 1, 1); ev(89, 1, 0, 1); ev(163, 1, 1, 1); ev(238, 1, 0, 1);
    ev(387, 1, 1, 1); ev(463, 1, 0, 1);
    goto_cyc(10); wr_pulse(8'h80);
    goto_cyc(470);
    chk_drained("five_step_even");

    // odd-parity write, expiry on a step point, rewrite while pending
    do_reset();
    ev(16, 1, 1, 1);
    ev(167, 1, 0, 1); ev(241, 1, 1, 1); ev(316, 1, 0, 1);
    ev(389, 0, 0, 0); ev(390, 1, 1, 0); ev(396, 0, 0, 1);
    ev(481, 1, 0, 1); ev(555, 1, 1, 1); ev(630, 1, 0, 1);
    ev(703, 0, 0, 0); ev(704, 1, 1, 0);
    goto_cyc(11);  wr_pulse(8'h80);
    goto_cyc(88);  wr_pulse(8'h00);
    goto_cyc(395); rd_pulse();
    goto_cyc(400); wr_pulse(8'h80);
    goto_cyc(402); wr_pulse(8'h00);
    goto_cyc(710);
    chk_drained("odd_collide_rewrite");

    // reset lands while a write is pending and alongside a fresh write strobe
    wr_pulse(8'h80);
    rst = 1'b1; wr = 1'b1; din = 8'hC0;
    @(posedge clk); #1;
    wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("midreset");
    ev(76, 1, 0, 1); ev(150, 1, 1, 1); ev(225, 1, 0, 1);
    ev(298, 0, 0, 0); ev(299, 1, 1, 0);
    goto_cyc(305);
    chk_drained("mid_pending_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
